fixed_to_float: RTL and testbench



---
 rtl/fixed_to_float.sv | 92 +++++++++
 tb/tb_fixed_to_float.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float.sv
// Converts a two's-complement fixed-point value to IEEE-754 single precision by
// sign/magnitude split followed by one-bit-per-cycle normalisation (exact, no rounding).
module fixed_to_float #(
    parameter int FLOAT_DATA_WIDTH  = 32,
    parameter int INTEGER_WIDTH     = 4,
    parameter int FRACTIONAL_WIDTH  = 20,
    parameter int CORDIC_DATA_WIDTH = INTEGER_WIDTH + FRACTIONAL_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clk_en,
    input  logic signed [CORDIC_DATA_WIDTH-1:0] data_fixed,
    output logic        [FLOAT_DATA_WIDTH-1:0]  result,
    output logic                                done,
    output logic                                busy
);

    localparam int W = CORDIC_DATA_WIDTH;
    // Exponent of the un-normalised magnitude when its MSB is taken as the hidden one.
    localparam logic [7:0] EXP_INIT = 8'(W - 1 - FRACTIONAL_WIDTH + 127);

    typedef enum logic [1:0] {IDLE, LOAD, NORM, OUT} state_t;

    state_t state, state_nxt;

    logic signed [W-1:0] data_p0;
    logic                sign_p1;
    logic        [W-1:0] mag_p1;
    logic        [7:0]   exp_p1;

    function automatic logic [W-1:0] abs_mag(input logic signed [W-1:0] x);
        // The most-negative input wraps to 2^(W-1), which is the correct unsigned magnitude.
        return x[W-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

    function automatic logic [31:0] pack_float(input logic       s,
                                               input logic [7:0] e,
                                               input logic [W-2:0] m);
        logic [22:0] frac;
        frac = 23'(m) << (24 - W);
        return {s, e, frac};
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (clk_en) state_nxt = LOAD;
            LOAD: state_nxt = (data_p0 == '0) ? OUT : NORM;
            NORM: if (mag_p1[W-1]) state_nxt = OUT;
            OUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state == OUT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_p0 <= '0;
            sign_p1 <= 1'b0;
            mag_p1  <= '0;
            exp_p1  <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: if (clk_en) data_p0 <= data_fixed;
                LOAD: begin
                    sign_p1 <= data_p0[W-1];
                    mag_p1  <= abs_mag(data_p0);
                    exp_p1  <= (data_p0 == '0) ? 8'd0 : EXP_INIT;
                end
                NORM: if (!mag_p1[W-1]) begin
                    mag_p1 <= mag_p1 << 1;
                    exp_p1 <= exp_p1 - 8'd1;
                end
                OUT: result <= FLOAT_DATA_WIDTH'(pack_float(sign_p1, exp_p1, mag_p1[W-2:0]));
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float.sv
// Directed-vector bench for fixed_to_float: table of conversions plus hand-built
// sequences for busy-time starts, mid-conversion reset and back-to-back operation.
module tb_fixed_to_float;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b0;
    logic [23:0] data_fixed = '0;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int errors = 0;
    int checks = 0;

    fixed_to_float dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .data_fixed (data_fixed),
        .result     (result),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] din;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts a conversion on the next edge (edge 0) and waits up to 40 edges for done.
    task automatic run_conv(input logic [23:0] din, output logic [31:0] res,
                            output int lat, output int busy_err);
        res = '0;
        lat = -1;
        busy_err = 0;
        clk_en = 1'b1;
        data_fixed = din;
        @(posedge clk); #1;
        clk_en = 1'b0;
        data_fixed = ~din;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                res = result;
                if (busy) busy_err++;
                break;
            end else if (!busy) begin
                busy_err++;
            end
        end
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          berr;
        int          ndone;
        int          e1, e2;
        logic [31:0] r1, r2;

        tbl[0]  = '{24'h100000, 32'h3F800000, 6};
        tbl[1]  = '{24'hF00000, 32'hBF800000, 6};
        tbl[2]  = '{24'h080000, 32'h3F000000, 7};
        tbl[3]  = '{24'h000001, 32'h35800000, 26};
        tbl[4]  = '{24'h800000, 32'hC1000000, 3};
        tbl[5]  = '{24'h7FFFFF, 32'h40FFFFFE, 4};
        tbl[6]  = '{24'h000000, 32'h00000000, 2};
        tbl[7]  = '{24'h09B74C, 32'h3F1B74C0, 7};
        tbl[8]  = '{24'hFFFFFF, 32'hB5800000, 26};
        tbl[9]  = '{24'h400000, 32'h40800000, 4};
        tbl[10] = '{24'hC00000, 32'hC0800000, 4};
        tbl[11] = '{24'h123456, 32'h3F91A2B0, 6};

        #12;
        chk("reset_result", result, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_conv(tbl[i].din, res, lat, berr);
            chk($sformatf("vec%0d_result", i), res, tbl[i].res);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_busy", i), 32'(berr), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'h0);
        end

        // clk_en pulsed while busy must be ignored
        clk_en = 1'b1;
        data_fixed = 24'h100000;
        @(posedge clk); #1;
        clk_en = 1'b0;
        data_fixed = 24'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clk_en = 1'b1;
        data_fixed = 24'h080000;
        @(posedge clk); #1;
        clk_en = 1'b0;
        ndone = 0; e1 = -1; r1 = '0;
        for (int n = 4; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (e1 < 0) begin e1 = n; r1 = result; end
            end
        end
        chk("busy_ign_count", 32'(ndone), 32'd1);
        chk("busy_ign_edge", 32'(e1), 32'd6);
        chk("busy_ign_result", r1, 32'h3F800000);
        chk("busy_ign_idle", {31'b0, busy}, 32'h0);

        // reset mid-conversion aborts without done
        clk_en = 1'b1;
        data_fixed = 24'h100000;
        @(posedge clk); #1;
        clk_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_result", result, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        ndone = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_conv(24'h09B74C, res, lat, berr);
        chk("after_abort_result", res, 32'h3F1B74C0);
        chk("after_abort_latency", 32'(lat), 32'd7);
        @(posedge clk); #1;

        // back-to-back: clk_en held high through the first conversion
        clk_en = 1'b1;
        data_fixed = 24'h100000;
        @(posedge clk); #1;
        data_fixed = 24'hF00000;
        ndone = 0; e1 = -1; e2 = -1; r1 = '0; r2 = '0;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk); #1;
            if (n == 7) clk_en = 1'b0;
            if (done) begin
                ndone++;
                if (e1 < 0) begin e1 = n; r1 = result; end
                else if (e2 < 0) begin e2 = n; r2 = result; end
            end
        end
        chk("b2b_count", 32'(ndone), 32'd2);
        chk("b2b_edge1", 32'(e1), 32'd6);
        chk("b2b_result1", r1, 32'h3F800000);
        chk("b2b_edge2", 32'(e2), 32'd13);
        chk("b2b_result2", r2, 32'hBF800000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
